register_file_1row_write_arbiter: RTL

- Write-side front end for the single-row latch register file (1 write port, N_READ read ports).
- Arbitrates N_PORTS requesters round-robin, merges byte-enabled partial writes with the current row contents, and drives the row's WriteEnable/WriteData.
- Outputs are registered, so the latch row sees a clean flop-driven enable and data.
- Also provides a synchronous clear of the row.

---
 rtl/register_file_1row_write_arbiter_if.sv | 14 +
 rtl/register_file_1row_write_arbiter.sv | 79 +++++++
 2 files changed

// File: rtl/register_file_1row_write_arbiter_if.sv
// Write-request bundle for the single-row register file write arbiter.
// Each requester owns one lane of the packed valid/ready/data/be vectors.
interface register_file_1row_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_PORTS    = 2
);
  logic [N_PORTS-1:0]                   req_valid_i;
  logic [N_PORTS-1:0]                   req_ready_o;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   req_data_i;
  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0] req_be_i;

  modport master (output req_valid_i, req_data_i, req_be_i, input  req_ready_o);
  modport slave  (input  req_valid_i, req_data_i, req_be_i, output req_ready_o);
endinterface

// File: rtl/register_file_1row_write_arbiter.sv
// Round-robin write arbiter for a single latch row: merges byte-enabled writes
// with the current row contents and drives a flop-clean WriteEnable/WriteData.
module register_file_1row_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_PORTS    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  register_file_1row_write_arbiter_if.slave req,
  input  logic [DATA_WIDTH-1:0] ReadData_i,
  output logic                  WriteEnable_o,
  output logic [DATA_WIDTH-1:0] WriteData_o
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [PTR_W:0]   IDX_N = (PTR_W+1)'(N_PORTS);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_PORTS - 1);

  logic [PTR_W-1:0]      ptr, win;
  logic [PTR_W:0]        idx;
  logic                  found, accept;
  logic [N_PORTS-1:0]    ready;
  logic [NB-1:0]         win_be;
  logic [DATA_WIDTH-1:0] win_data, base, merged;

  // First valid port at or above ptr, wrapping; idx carries one spare bit for the sum.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= IDX_N) idx = idx - IDX_N;
      if (!found && req.req_valid_i[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  assign accept = found & ~clear_i;

  always_comb begin
    ready = '0;
    if (accept && rst_n) ready[win] = 1'b1;
  end
  assign req.req_ready_o = ready;

  assign win_be   = req.req_be_i[win];
  assign win_data = req.req_data_i[win];
  // The row only latches one edge after WriteEnable, so forward the in-flight word.
  assign base     = WriteEnable_o ? WriteData_o : ReadData_i;

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign merged[b*8 +: 8] = win_be[b] ? win_data[b*8 +: 8] : base[b*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      WriteEnable_o <= 1'b0;
      WriteData_o   <= '0;
    end else if (clear_i) begin
      WriteEnable_o <= 1'b1;
      WriteData_o   <= '0;
    end else if (found) begin
      ptr <= (win == LAST) ? '0 : win + 1'b1;
      if (|win_be) begin
        WriteEnable_o <= 1'b1;
        WriteData_o   <= merged;
      end else begin
        WriteEnable_o <= 1'b0;
      end
    end else begin
      WriteEnable_o <= 1'b0;
    end
  end
endmodule
